rgb_layer_compositor: RTL and testbench
=======================================

Name: rgb_layer_compositor

Overview:
- Parametrised successor to the hand-written top-level RGB priority mux.
- Merges NUM_LAYERS sprite/overlay layers by fixed priority, with per-layer enables double-buffered at frame boundaries.
- Adds frame-timed screen effects: hit flash, fade-out to black, fade-in.
- Sits between the sprite units and the VGA DAC pins, replacing the rgb_next/rgb_reg logic in the display top.

Parameters:
- NUM_LAYERS, 12: number of input layers; index 0 has highest priority.
- COLOR_W, 12: RGB width, 3 equal channels (must be a multiple of 3).
- BG_COLOR, 12'h000: colour used when no enabled layer is on.
- FLASH_FRAMES, 8: length of the flash effect in frames.
- FADE_RATE, 2: frames per brightness step during fades.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high
- video_on  in  1  active-video qualifier, aligned with layer inputs
- frame_start  in  1  one-cycle pulse at start of vertical blank
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags
- layer_rgb  in  NUM_LAYERS*COLOR_W  packed colours; layer i at bits [i*COLOR_W +: COLOR_W]
- layer_en_next  in  NUM_LAYERS  enable mask, shadowed at frame_start
- fx_valid  in  1  effect command strobe
- fx_cmd  in  2  0=none, 1=flash, 2=fade_out, 3=fade_in
- rgb  out  COLOR_W  registered pixel colour to DAC
- video_on_q  out  1  video_on delayed to match rgb
- fx_busy  out  1  high in FLASH, FADE_OUT, FADE_IN
- level  out  5  current brightness, 0..16

Behaviour:
- Reset values:
  - rgb=0, video_on_q=0, fx_busy=0.
  - level=16, state=IDLE.
  - layer_en_q=all ones; pipeline registers cleared.
  - Reset asserted mid-effect aborts the effect immediately.
- Enable shadow:
  - layer_en_q <= layer_en_next only on cycles with frame_start=1.
  - Mid-frame changes to layer_en_next have no visible effect.
- Pipeline, 2-cycle latency from inputs to rgb/video_on_q:
  - Stage 1 (registered): winner = lowest i with layer_on[i] & layer_en_q[i]; colour = layer_rgb[i], or BG_COLOR if there is no winner. video_on is carried alongside.
  - Stage 2 (registered): effect processing.
    - Each channel c (width CW=COLOR_W/3) -> (c*level)>>4, computed at CW+5 bits and truncated to CW. level=16 is identity.
    - If in FLASH and flash_cnt[0]==1, the scaled colour is bitwise inverted.
    - If delayed video_on=0, rgb=0 regardless of effect.
- Effect FSM: states IDLE, FLASH, FADE_OUT, BLACK, FADE_IN. frame_cnt counts frame_start pulses inside a state.
  - IDLE: cmd flash -> FLASH with flash_cnt=0. cmd fade_out -> FADE_OUT. fade_in/none ignored.
  - FLASH: flash_cnt increments per frame_start; at FLASH_FRAMES-1 -> IDLE. fade_out aborts to FADE_OUT. Other cmds ignored.
  - FADE_OUT: every FADE_RATE frames level-=1; when level reaches 0 -> BLACK. fade_in -> FADE_IN from current level. Other cmds ignored.
  - BLACK: level holds 0 indefinitely. Only fade_in accepted -> FADE_IN.
  - FADE_IN: every FADE_RATE frames level+=1; at 16 -> IDLE. fade_out -> FADE_OUT from current level.
- Level saturates at 0 and 16 and never wraps.
- Ignored commands have no side effects.
- Accepted command: state changes on the next edge, frame_cnt resets to 0.
- Simultaneous fx_valid and frame_start: the command wins and the frame_start is consumed without advancing any counter. The enable shadow still loads.
- fx_cmd=0 with fx_valid is a no-op.

Decomposition:
- Shared package rgb_fx_pkg holds:
  - fx_state enum (IDLE, FLASH, FADE_OUT, BLACK, FADE_IN).
  - fx_cmd encodings.
  - LVL_MAX=16 and LVL_W=5.
- Sub-module layer_priority_sel: parametrised priority encoder/mux for stage 1, purely combinational, instantiated once.

Test Plan:
- Priority: layers 0,3 on, all enabled, colours 12'hF00/12'h0F0 -> rgb=12'hF00 two cycles later. Disable layer 0 via layer_en_next + frame_start -> 12'h0F0. Mid-frame change has no effect until frame_start.
- No layer on, video_on=1 -> BG_COLOR. video_on=0 with layers on -> rgb=0; video_on_q tracks video_on at 2-cycle delay.
- Flash: cmd flash in IDLE, layer colour 12'h123 -> alternate frames show 12'hEDC. fx_busy=1 for 8 frames, then IDLE with colour 12'h123.
- Fade: fade_out with FADE_RATE=2 -> level 16->0 over 32 frames, colour 12'hFFF reaches 12'h777 at level 8, then BLACK. fade_in -> back to 16 after 32 frames, IDLE.
- Simultaneous fx_valid(fade_out) with frame_start in IDLE -> level stays 16 that frame. fade_in issued during FADE_OUT at level 10 -> reverses from 10 upward.
- Assert reset during FADE_OUT at level 5 -> next cycle level=16, IDLE, rgb=0, layer_en_q all ones.

Source files
------------

// File: rtl/rgb_fx_pkg.sv
// Shared types for the RGB compositor: effect states, command encodings, brightness range.
// Purely declarative; no logic and no latency.
package rgb_fx_pkg;

  typedef enum logic [2:0] {
    FX_IDLE     = 3'd0,
    FX_FLASH    = 3'd1,
    FX_FADE_OUT = 3'd2,
    FX_BLACK    = 3'd3,
    FX_FADE_IN  = 3'd4
  } fx_state_t;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_FLASH    = 2'd1,
    CMD_FADE_OUT = 2'd2,
    CMD_FADE_IN  = 2'd3
  } fx_cmd_t;

  localparam int LVL_MAX = 16;
  localparam int LVL_W   = 5;

  function automatic logic fx_is_busy(fx_state_t s);
    return (s == FX_FLASH) || (s == FX_FADE_OUT) || (s == FX_FADE_IN);
  endfunction

endpackage

// File: rtl/rgb_layer_compositor_if.sv
// Pixel/effect bus between the sprite units and the compositor; master drives layers and commands.
// Wires only; the compositor has no backpressure, every pixel is accepted each cycle.
interface rgb_layer_compositor_if
  import rgb_fx_pkg::*;
#(
  parameter int NUM_LAYERS = 12,
  parameter int COLOR_W    = 12
);
  logic                          video_on;
  logic                          frame_start;
  logic [NUM_LAYERS-1:0]         layer_on;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         layer_en_next;
  logic                          fx_valid;
  logic [1:0]                    fx_cmd;
  logic [COLOR_W-1:0]            rgb;
  logic                          video_on_q;
  logic                          fx_busy;
  logic [LVL_W-1:0]              level;

  modport master (
    output video_on, frame_start, layer_on, layer_rgb, layer_en_next, fx_valid, fx_cmd,
    input  rgb, video_on_q, fx_busy, level
  );

  modport slave (
    input  video_on, frame_start, layer_on, layer_rgb, layer_en_next, fx_valid, fx_cmd,
    output rgb, video_on_q, fx_busy, level
  );
endinterface

// File: rtl/layer_priority_sel.sv
// Fixed-priority layer select: lowest enabled, active index wins, else background colour.
// Combinational, zero latency; no backpressure.
module layer_priority_sel #(
  parameter int                 NUM_LAYERS = 12,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
  input  logic [NUM_LAYERS-1:0]         i_layer_on,
  input  logic [NUM_LAYERS-1:0]         i_layer_en,
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_rgb,
  output logic [COLOR_W-1:0]            o_rgb
);

  // Walk from the lowest priority upward so the last hit (lowest index) sticks.
  always_comb begin
    o_rgb = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_layer_on[i] && i_layer_en[i]) begin
        o_rgb = i_layer_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/rgb_layer_compositor.sv
// Layer compositor with frame-timed flash/fade effects driving the DAC pins.
// Two-cycle latency from layer inputs to rgb/video_on_q; no backpressure.
module rgb_layer_compositor
  import rgb_fx_pkg::*;
#(
  parameter int                 NUM_LAYERS   = 12,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
  parameter int                 FLASH_FRAMES = 8,
  parameter int                 FADE_RATE    = 2
) (
  input logic                  clk,
  input logic                  reset,
  rgb_layer_compositor_if.slave bus
);

  localparam int               CW         = COLOR_W / 3;
  localparam int               FCW        = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int               RCW        = (FADE_RATE > 1) ? $clog2(FADE_RATE) : 1;
  localparam logic [FCW-1:0]   FLASH_LAST = FCW'(FLASH_FRAMES - 1);
  localparam logic [RCW-1:0]   RATE_LAST  = RCW'(FADE_RATE - 1);
  localparam logic [LVL_W-1:0] LVL_TOP    = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

  fx_state_t           r_state, w_state_n;
  logic [LVL_W-1:0]    r_level, w_level_n;
  logic [RCW-1:0]      r_frame_cnt, w_frame_cnt_n;
  logic [FCW-1:0]      r_flash_cnt, w_flash_cnt_n;
  logic [NUM_LAYERS-1:0] r_layer_en_q;
  logic [COLOR_W-1:0]  r_s1_rgb, r_rgb;
  logic                r_s1_vid, r_vid_q;
  logic [COLOR_W-1:0]  w_sel_rgb, w_scaled, w_fx_rgb;
  fx_cmd_t             w_cmd;
  logic                w_cmd_ok;

  assign w_cmd = fx_cmd_t'(bus.fx_cmd);

  layer_priority_sel #(
    .NUM_LAYERS(NUM_LAYERS),
    .COLOR_W   (COLOR_W),
    .BG_COLOR  (BG_COLOR)
  ) u_sel (
    .i_layer_on (bus.layer_on),
    .i_layer_en (r_layer_en_q),
    .i_layer_rgb(bus.layer_rgb),
    .o_rgb      (w_sel_rgb)
  );

  always_comb begin
    w_cmd_ok      = 1'b0;
    w_state_n     = r_state;
    w_level_n     = r_level;
    w_frame_cnt_n = r_frame_cnt;
    w_flash_cnt_n = r_flash_cnt;
    case (r_state)
      FX_IDLE:               w_cmd_ok = (w_cmd == CMD_FLASH) || (w_cmd == CMD_FADE_OUT);
      FX_FLASH, FX_FADE_IN:  w_cmd_ok = (w_cmd == CMD_FADE_OUT);
      FX_FADE_OUT, FX_BLACK: w_cmd_ok = (w_cmd == CMD_FADE_IN);
      default:               w_cmd_ok = 1'b0;
    endcase

    // An accepted command swallows a coincident frame_start.
    if (bus.fx_valid && w_cmd_ok) begin
      w_frame_cnt_n = '0;
      w_flash_cnt_n = '0;
      case (w_cmd)
        CMD_FLASH:    w_state_n = FX_FLASH;
        CMD_FADE_OUT: w_state_n = FX_FADE_OUT;
        default:      w_state_n = FX_FADE_IN;
      endcase
    end else if (bus.frame_start) begin
      case (r_state)
        FX_FLASH: begin
          if (r_flash_cnt == FLASH_LAST) begin
            w_state_n     = FX_IDLE;
            w_flash_cnt_n = '0;
          end else begin
            w_flash_cnt_n = r_flash_cnt + 1'b1;
          end
        end
        FX_FADE_OUT: begin
          if (r_frame_cnt == RATE_LAST) begin
            w_frame_cnt_n = '0;
            if (r_level <= LVL_ONE) begin
              w_level_n = '0;
              w_state_n = FX_BLACK;
            end else begin
              w_level_n = r_level - LVL_ONE;
            end
          end else begin
            w_frame_cnt_n = r_frame_cnt + 1'b1;
          end
        end
        FX_FADE_IN: begin
          if (r_frame_cnt == RATE_LAST) begin
            w_frame_cnt_n = '0;
            if (r_level >= LVL_TOP - LVL_ONE) begin
              w_level_n = LVL_TOP;
              w_state_n = FX_IDLE;
            end else begin
              w_level_n = r_level + LVL_ONE;
            end
          end else begin
            w_frame_cnt_n = r_frame_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FX_IDLE;
      r_level      <= LVL_TOP;
      r_frame_cnt  <= '0;
      r_flash_cnt  <= '0;
      r_layer_en_q <= '1;
    end else begin
      r_state     <= w_state_n;
      r_level     <= w_level_n;
      r_frame_cnt <= w_frame_cnt_n;
      r_flash_cnt <= w_flash_cnt_n;
      if (bus.frame_start) begin
        r_layer_en_q <= bus.layer_en_next;
      end
    end
  end

  // Per-channel brightness scale; level 16 is a pure shift-back identity.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CW+4:0] w_prod;
    assign w_prod = {5'b0, r_s1_rgb[c*CW +: CW]} * {{CW{1'b0}}, r_level};
    assign w_scaled[c*CW +: CW] = w_prod[CW+3:4];
  end

  assign w_fx_rgb = ((r_state == FX_FLASH) && r_flash_cnt[0]) ? ~w_scaled : w_scaled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_rgb <= '0;
      r_s1_vid <= 1'b0;
      r_rgb    <= '0;
      r_vid_q  <= 1'b0;
    end else begin
      r_s1_rgb <= w_sel_rgb;
      r_s1_vid <= bus.video_on;
      r_rgb    <= r_s1_vid ? w_fx_rgb : '0;
      r_vid_q  <= r_s1_vid;
    end
  end

  assign bus.rgb        = r_rgb;
  assign bus.video_on_q = r_vid_q;
  assign bus.fx_busy    = fx_is_busy(r_state);
  assign bus.level      = r_level;

endmodule

// File: tb/tb_rgb_layer_compositor.sv
// Scoreboard bench for rgb_layer_compositor: a behavioural model predicts each pixel at drive time.
module tb_rgb_layer_compositor;
  import rgb_fx_pkg::*;

  localparam int          NL        = 12;
  localparam int          CWID      = 12;
  localparam logic [11:0] BG        = 12'h05A;
  localparam int          FLASH_N   = 8;
  localparam int          RATE      = 2;
  localparam int          FRAME_LEN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CWID)) bus ();

  rgb_layer_compositor #(
    .NUM_LAYERS  (NL),
    .COLOR_W     (CWID),
    .BG_COLOR    (BG),
    .FLASH_FRAMES(FLASH_N),
    .FADE_RATE   (RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [12:0] exp_q[$];
  int          m_state, m_level, m_fcnt, m_flash;
  logic [11:0] m_en_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pick(logic [11:0] on, logic [11:0] en, logic [143:0] cols);
    for (int i = 0; i < NL; i++) begin
      if (on[i] && en[i]) return cols[i*12 +: 12];
    end
    return BG;
  endfunction

  function automatic logic [11:0] fx_pix(logic [11:0] c, bit vid, int st, int lvl, int fl);
    logic [11:0] r;
    if (!vid) return 12'h000;
    for (int ch = 0; ch < 3; ch++) begin
      r[ch*4 +: 4] = 4'((int'(c[ch*4 +: 4]) * lvl) / 16);
    end
    if (st == 1 && (fl % 2) == 1) r = ~r;
    return r;
  endfunction

  function automatic bit m_busy(int st);
    return (st == 1) || (st == 2) || (st == 4);
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 16; m_fcnt = 0; m_flash = 0; m_en_q = '1;
    exp_q.delete();
    exp_q.push_back(13'h0);
  endtask

  // States: 0 idle, 1 flash, 2 fade_out, 3 black, 4 fade_in.
  task automatic model_advance(input bit fs, input bit fxv, input logic [1:0] cmd, input logic [11:0] en_next);
    int tgt;
    tgt = -1;
    if (fs) m_en_q = en_next;
    if (fxv) begin
      if (m_state == 0 && cmd == 2'd1) tgt = 1;
      if (cmd == 2'd2 && (m_state == 0 || m_state == 1 || m_state == 4)) tgt = 2;
      if (cmd == 2'd3 && (m_state == 2 || m_state == 3)) tgt = 4;
    end
    if (tgt >= 0) begin
      m_state = tgt; m_fcnt = 0; m_flash = 0;
    end else if (fs) begin
      if (m_state == 1) begin
        if (m_flash == FLASH_N - 1) begin m_state = 0; m_flash = 0; end
        else m_flash++;
      end else if (m_state == 2 || m_state == 4) begin
        m_fcnt++;
        if (m_fcnt == RATE) begin
          m_fcnt = 0;
          if (m_state == 2) begin
            if (m_level > 0) m_level--;
            if (m_level == 0) m_state = 3;
          end else begin
            if (m_level < 16) m_level++;
            if (m_level == 16) m_state = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit vid, input bit fs, input bit fxv = 1'b0, input logic [1:0] cmd = 2'd0);
    logic [11:0] col;
    logic [12:0] e;
    bus.video_on = vid; bus.frame_start = fs; bus.fx_valid = fxv; bus.fx_cmd = cmd;
    col = pick(bus.layer_on, m_en_q, bus.layer_rgb);
    model_advance(fs, fxv, cmd, bus.layer_en_next);
    exp_q.push_back({vid, fx_pix(col, vid, m_state, m_level, m_flash)});
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("pix", {19'h0, bus.video_on_q, bus.rgb}, {19'h0, e});
    end
    chk("level", 32'(bus.level), 32'(m_level));
    chk("busy", 32'(bus.fx_busy), 32'(m_busy(m_state)));
    bus.frame_start = 1'b0; bus.fx_valid = 1'b0; bus.fx_cmd = 2'd0;
  endtask

  task automatic frames(input int n, input bit vid = 1'b1);
    repeat (n) begin
      cyc(vid, 1'b1);
      repeat (FRAME_LEN - 1) cyc(vid, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.video_on = 1'b0; bus.frame_start = 1'b0; bus.fx_valid = 1'b0; bus.fx_cmd = 2'd0;
    bus.layer_on = '0; bus.layer_en_next = '1;
    for (int i = 0; i < NL; i++) bus.layer_rgb[i*12 +: 12] = 12'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(bus.rgb), 32'h0);
    chk("rst_vq", 32'(bus.video_on_q), 32'h0);
    chk("rst_busy", 32'(bus.fx_busy), 32'h0);
    chk("rst_level", 32'(bus.level), 32'd16);
    reset = 1'b0;
    model_reset();

    // Priority and enable shadowing
    bus.layer_rgb[0 +: 12]  = 12'hF00;
    bus.layer_rgb[36 +: 12] = 12'h0F0;
    bus.layer_on = 12'b0000_0000_1001;
    repeat (4) cyc(1'b1, 1'b0);
    chk("prio0", 32'(bus.rgb), 32'h0F00);
    bus.layer_en_next = 12'hFFE;
    repeat (4) cyc(1'b1, 1'b0);
    chk("en_midframe", 32'(bus.rgb), 32'h0F00);
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    chk("en_shadow", 32'(bus.rgb), 32'h00F0);
    bus.layer_en_next = '1;
    cyc(1'b1, 1'b1);

    // Background and blanking
    bus.layer_on = '0;
    repeat (3) cyc(1'b1, 1'b0);
    chk("bg", 32'(bus.rgb), 32'(BG));
    bus.layer_on = 12'h001;
    repeat (3) cyc(1'b0, 1'b0);
    chk("blank_rgb", 32'(bus.rgb), 32'h0);
    chk("blank_vq", 32'(bus.video_on_q), 32'h0);

    // Random mix of layers, enables, frame starts and blanking
    for (int k = 0; k < 24; k++) begin
      bus.layer_on      = 12'($urandom);
      bus.layer_en_next = 12'($urandom);
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end
    bus.layer_en_next = '1;
    frames(1);

    // Flash, including ignored commands mid-flash
    bus.layer_on = 12'h020;
    bus.layer_rgb[60 +: 12] = 12'h123;
    cyc(1'b1, 1'b0, 1'b1, CMD_FLASH);
    frames(1);
    chk("flash_inv", 32'(bus.rgb), 32'h0EDC);
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_IN);
    cyc(1'b1, 1'b0, 1'b1, CMD_FLASH);
    frames(7);
    chk("flash_end_busy", 32'(bus.fx_busy), 32'h0);
    chk("flash_end_rgb", 32'(bus.rgb), 32'h0123);

    // Full fade out to black, then fade in
    bus.layer_rgb[60 +: 12] = 12'hFFF;
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_OUT);
    frames(16);
    chk("fade_half_lvl", 32'(bus.level), 32'd8);
    chk("fade_half_rgb", 32'(bus.rgb), 32'h0777);
    frames(16);
    chk("black_lvl", 32'(bus.level), 32'd0);
    chk("black_rgb", 32'(bus.rgb), 32'h0);
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_OUT);
    cyc(1'b1, 1'b0, 1'b1, CMD_FLASH);
    frames(3);
    chk("black_hold", 32'(bus.level), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_IN);
    frames(32);
    chk("fadein_lvl", 32'(bus.level), 32'd16);
    chk("fadein_busy", 32'(bus.fx_busy), 32'h0);
    chk("fadein_rgb", 32'(bus.rgb), 32'h0FFF);

    // Command coincident with frame_start, then reversal at level 10
    cyc(1'b1, 1'b1, 1'b1, CMD_FADE_OUT);
    chk("simul_lvl", 32'(bus.level), 32'd16);
    frames(12);
    chk("lvl10", 32'(bus.level), 32'd10);
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_IN);
    frames(2);
    chk("reverse", 32'(bus.level), 32'd11);
    bus.layer_en_next = '0;
    cyc(1'b1, 1'b0, 1'b1, CMD_FADE_OUT);
    frames(12);
    chk("lvl5", 32'(bus.level), 32'd5);

    // Asynchronous reset mid-fade
    reset = 1'b1;
    #1;
    chk("arst_level", 32'(bus.level), 32'd16);
    chk("arst_busy", 32'(bus.fx_busy), 32'h0);
    chk("arst_rgb", 32'(bus.rgb), 32'h0);
    chk("arst_vq", 32'(bus.video_on_q), 32'h0);
    chk("arst_en_q", 32'(dut.r_layer_en_q), 32'hFFF);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
